// File: rtl/ti_roic_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ti_roic_spi_pkg
// Purpose  : Shared frame geometry, FSM states and request record for the
//            TI-ROIC register SPI master.
// Revision : 1.0
// ============================================================================
package ti_roic_spi_pkg;

    localparam int ROIC_FRAME_BITS = 24;
    localparam int ROIC_ADDR_BITS  = 8;
    localparam int ROIC_DATA_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } roic_state_t;

    typedef struct packed {
        logic                      rd;
        logic [ROIC_ADDR_BITS-1:0] addr;
        logic [ROIC_DATA_BITS-1:0] data;
    } roic_req_t;

    // Read frames carry an all-zero payload; the ROIC drives data back instead.
    function automatic logic [ROIC_FRAME_BITS-1:0] roic_frame_word(input roic_req_t req);
        return {req.addr, (req.rd ? 16'h0000 : req.data)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ti_roic_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : ti_roic_sclk_gen
// Purpose  : SCLK divider (CPOL=0) with rise/fall strobes; idles low when
//            disabled.
// Revision : 1.0
// ============================================================================
module ti_roic_sclk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_sclk;
    logic               w_wrap;

    // Strobes flag the clk edge on which the SCLK level toggles.
    assign w_wrap      = i_en && (r_div == c_DIV_LAST);
    assign o_rise_tick = w_wrap && !r_sclk;
    assign o_fall_tick = w_wrap && r_sclk;
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_div <= w_wrap ? '0 : r_div + c_DIV_W'(1);
            if (w_wrap) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ti_roic_reg_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : ti_roic_reg_spi_master
// Purpose  : Serialises register-map commands into 24-bit ROIC SPI frames
//            and captures read-back data. Optional FIFO: TI_ROIC_SPI_QUEUE_EN.
// Revision : 1.0
// ============================================================================
module ti_roic_reg_spi_master
    import ti_roic_spi_pkg::*;
#(
    parameter int CLK_DIV   = 10,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int FRAME_GAP = 8
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [1:0]  ti_roic_str,
    input  logic [15:0] ti_roic_reg_addr,
    input  logic [15:0] ti_roic_reg_data,
    output logic        roic_sen,
    output logic        roic_sclk,
    output logic        roic_sdata,
    input  logic        roic_sdout,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        err_overrun
);

    localparam logic [15:0] c_SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] c_HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] c_GAP_LAST   = 16'(FRAME_GAP - 1);
    localparam logic [4:0]  c_LAST_BIT   = 5'(ROIC_FRAME_BITS - 1);
    localparam logic [4:0]  c_BIT_SAT    = 5'(ROIC_FRAME_BITS);
    localparam logic [4:0]  c_DATA_BIT0  = 5'(ROIC_ADDR_BITS);

    roic_state_t r_state, w_state_next;
    logic [15:0] r_cnt;
    logic [4:0]  r_bit_cnt;
    logic [23:0] r_shift;
    logic [15:0] r_cap;
    logic [1:0]  r_str_q;
    logic        r_rd, r_sen, r_sdata, r_done, r_rd_valid, r_err;
    logic [15:0] r_rd_data;
    logic        r_sdo_meta, r_sdo_sync;

    logic        w_wr_rise, w_rd_rise, w_req_any, w_both;
    logic        w_start, w_drop, w_pending, w_gap_last;
    logic        w_fall_tick, w_rise_tick;
    roic_req_t   w_req_in, w_start_req;
    logic [23:0] w_start_word;

    assign w_wr_rise  = ti_roic_str[0] & ~r_str_q[0];
    assign w_rd_rise  = ti_roic_str[1] & ~r_str_q[1];
    assign w_req_any  = w_wr_rise | w_rd_rise;
    assign w_both     = w_wr_rise & w_rd_rise;
    assign w_gap_last = (r_state == GAP) && (r_cnt == c_GAP_LAST);

    // A simultaneous write and read resolves to the write.
    assign w_req_in = '{rd:   w_rd_rise & ~w_wr_rise,
                        addr: ti_roic_reg_addr[7:0],
                        data: ti_roic_reg_data};

`ifdef TI_ROIC_SPI_QUEUE_EN
    roic_req_t  r_fifo [4];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_fifo_cnt;
    logic       w_fifo_empty, w_fifo_full, w_direct, w_push, w_pop;

    assign w_fifo_empty = (r_fifo_cnt == 3'd0);
    assign w_fifo_full  = (r_fifo_cnt == 3'd4);
    assign w_direct     = (r_state == IDLE) && w_fifo_empty;
    assign w_push       = w_req_any && !w_direct && !w_fifo_full;
    assign w_pop        = !w_fifo_empty && ((r_state == IDLE) || w_gap_last);
    assign w_start      = w_pop || (w_direct && w_req_any);
    assign w_start_req  = w_pop ? r_fifo[r_rd_ptr] : w_req_in;
    assign w_drop       = w_both || (w_req_any && !w_direct && w_fifo_full);
    assign w_pending    = !w_fifo_empty;

    always_ff @(posedge clk_100mhz) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_req_in;
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end
`else
    assign w_start     = (r_state == IDLE) && w_req_any;
    assign w_start_req = w_req_in;
    assign w_drop      = w_both || (w_req_any && (r_state != IDLE));
    assign w_pending   = 1'b0;
`endif

    assign w_start_word = roic_frame_word(w_start_req);

    ti_roic_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk_100mhz),
        .rst         (reset),
        .i_en        (r_state == SHIFT),
        .o_sclk      (roic_sclk),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    // The phase counter restarts on every state change.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_next = SETUP;
            SETUP:   if (r_cnt == c_SETUP_LAST) w_state_next = SHIFT;
            SHIFT:   if (w_fall_tick && (r_bit_cnt == c_LAST_BIT)) w_state_next = HOLD;
            HOLD:    if (r_cnt == c_HOLD_LAST) w_state_next = GAP;
            GAP:     if (w_gap_last) w_state_next = w_start ? SETUP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_sdo_meta <= 1'b0;
            r_sdo_sync <= 1'b0;
        end else begin
            r_sdo_meta <= roic_sdout;
            r_sdo_sync <= r_sdo_meta;
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_str_q    <= '0;
            r_sen      <= 1'b1;
            r_sdata    <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_shift    <= '0;
            r_rd       <= 1'b0;
            r_bit_cnt  <= '0;
            r_cap      <= '0;
        end else begin
            r_str_q    <= ti_roic_str;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_shift   <= w_start_word;
                r_rd      <= w_start_req.rd;
                r_sdata   <= w_start_word[23];
                r_sen     <= 1'b0;
                r_bit_cnt <= '0;
            end
            // Falling SCLK closes a bit: capture the ROIC bit, present the next MOSI bit.
            if ((r_state == SHIFT) && w_fall_tick) begin
                if (r_bit_cnt != c_BIT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                if (r_bit_cnt != c_LAST_BIT) begin
                    r_shift <= {r_shift[22:0], 1'b0};
                    r_sdata <= r_shift[22];
                end
                if (r_bit_cnt >= c_DATA_BIT0) begin
                    r_cap <= {r_cap[14:0], r_sdo_sync};
                end
            end
            if ((r_state == HOLD) && (r_cnt == c_HOLD_LAST)) begin
                r_sen      <= 1'b1;
                r_sdata    <= 1'b0;
                r_done     <= 1'b1;
                r_rd_valid <= r_rd;
                if (r_rd) begin
                    r_rd_data <= r_cap;
                end
            end
        end
    end

    assign roic_sen    = r_sen;
    assign roic_sdata  = r_sdata;
    assign done        = r_done;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign err_overrun = r_err;
    assign busy        = ((r_state != IDLE) && !(w_gap_last && !w_pending)) || w_pending;

    logic w_unused;
    assign w_unused = &{1'b0, ti_roic_reg_addr[15:8], w_rise_tick, r_shift[23]};

endmodule
`default_nettype wire

// File: tb/tb_ti_roic_reg_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ti_roic_reg_spi_master
// Purpose  : Self-checking bench with a ROIC pin model and frame scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ti_roic_reg_spi_master;

    localparam int CLK_DIV   = 2;
    localparam int CS_SETUP  = 1;
    localparam int CS_HOLD   = 1;
    localparam int FRAME_GAP = 3;
    localparam int LATENCY   = 1 + CS_SETUP + 48 * CLK_DIV + CS_HOLD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  str = 2'b00;
    logic [15:0] reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic        roic_sen, roic_sclk, roic_sdata, busy, done, rd_valid, err_overrun;
    logic        roic_sdout = 1'b0;
    logic [15:0] rd_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ti_roic_reg_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .FRAME_GAP(FRAME_GAP)
    ) dut (
        .clk_100mhz(clk), .reset(reset), .ti_roic_str(str),
        .ti_roic_reg_addr(reg_addr), .ti_roic_reg_data(reg_data),
        .roic_sen(roic_sen), .roic_sclk(roic_sclk), .roic_sdata(roic_sdata),
        .roic_sdout(roic_sdout), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ROIC pin model and scoreboard feed.
    logic [23:0] frm_q[$];
    int          bits_q[$];
    int          done_q[$];
    logic        vld_q[$];
    logic [15:0] rdd_q[$];
    logic [15:0] m_ret = '0;
    logic [23:0] m_retw, m_rx;
    int          m_nbits, m_pos, m_high_run, m_min_gap, m_nframes, m_stray;
    logic        m_prev_sen = 1'b1, m_prev_sclk = 1'b0;

    always @(negedge clk) begin
        m_retw = {8'h00, m_ret};
        if (!roic_sen) begin
            if (m_prev_sen) begin
                if (m_nframes > 0 && m_high_run < m_min_gap) m_min_gap = m_high_run;
                m_nframes++;
                m_rx = '0; m_nbits = 0; m_pos = 0;
                roic_sdout = m_retw[23];
            end
            if (roic_sclk && !m_prev_sclk) begin
                m_rx = {m_rx[22:0], roic_sdata};
                m_nbits++;
            end
            if (!roic_sclk && m_prev_sclk) begin
                m_pos++;
                roic_sdout = (m_pos < 24) ? m_retw[23-m_pos] : 1'b0;
            end
            m_high_run = 0;
        end else begin
            if (!m_prev_sen) begin
                frm_q.push_back(m_rx);
                bits_q.push_back(m_nbits);
            end
            m_high_run++;
        end
        if (done) begin
            done_q.push_back(cyc);
            vld_q.push_back(rd_valid);
            rdd_q.push_back(rd_data);
        end else if (rd_valid) begin
            m_stray++;
        end
        m_prev_sen  = roic_sen;
        m_prev_sclk = roic_sclk;
    end

    task automatic clear_mon();
        frm_q.delete(); bits_q.delete(); done_q.delete(); vld_q.delete(); rdd_q.delete();
        m_nframes = 0; m_min_gap = 1000; m_stray = 0;
    endtask

    task automatic do_req(input logic [1:0] s, input logic [7:0] a, input logic [15:0] d,
                          output int t);
        logic [7:0] junk;
        junk = 8'($urandom);
        @(negedge clk);
        reg_addr = {junk, a};
        reg_data = d;
        str = s;
        t = cyc;
        @(negedge clk);
        str = 2'b00;
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (!busy && roic_sen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({roic_sen, roic_sclk, roic_sdata, busy, done, rd_valid, err_overrun, rd_data}
            !== {1'b1, 6'b000000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: got sen=%b sclk=%b sdata=%b busy=%b done=%b vld=%b err=%b rd=%h",
                     roic_sen, roic_sclk, roic_sdata, busy, done, rd_valid, err_overrun, rd_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_basic();
        int t; bit ok;
        clear_mon();
        do_req(2'b01, 8'h5A, 16'h1234, t);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_req: got %b want 1", busy); end
        wait_quiet(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout: frame did not finish"); end
        checks++;
        if (frm_q.size() != 1 || frm_q[0] !== 24'h5A1234 || bits_q[0] != 24) begin
            errors++;
            $display("FAIL write_frame: got n=%0d word=%h bits=%0d want 1 5a1234 24",
                     frm_q.size(), frm_q[0], bits_q[0]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + LATENCY) begin
            errors++;
            $display("FAIL write_latency: got n=%0d at %0d want 1 at %0d", done_q.size(), done_q[0], t + LATENCY);
        end
        checks++;
        if (vld_q[0] !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL write_flags: got rd_valid=%b err=%b want 0 0", vld_q[0], err_overrun);
        end
    endtask

    task automatic test_read_basic();
        int t; bit ok;
        clear_mon();
        m_ret = 16'hBEEF;
        do_req(2'b10, 8'h03, 16'($urandom), t);
        wait_quiet(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_timeout: frame did not finish"); end
        checks++;
        if (frm_q.size() != 1 || frm_q[0] !== 24'h030000) begin
            errors++;
            $display("FAIL read_frame: got n=%0d word=%h want 1 030000", frm_q.size(), frm_q[0]);
        end
        checks++;
        if (done_q.size() != 1 || vld_q[0] !== 1'b1 || rdd_q[0] !== 16'hBEEF || m_stray != 0) begin
            errors++;
            $display("FAIL read_data: got dones=%0d vld=%b data=%h stray=%0d want 1 1 beef 0",
                     done_q.size(), vld_q[0], rdd_q[0], m_stray);
        end
        checks++;
        if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL read_hold: got %h want beef", rd_data); end
    endtask

    task automatic test_random(inout logic [15:0] last_rd);
        int t; bit ok; bit rd;
        logic [7:0] a; logic [15:0] d; logic [23:0] exp_word;
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            rd = 1'($urandom_range(0, 1));
            a = 8'($urandom); d = 16'($urandom); m_ret = 16'($urandom);
            exp_word = rd ? {a, 16'h0000} : {a, d};
            if (rd) last_rd = m_ret;
            do_req(rd ? 2'b10 : 2'b01, a, d, t);
            wait_quiet(400, ok);
            checks++;
            if (!ok || frm_q.size() != 1 || frm_q[0] !== exp_word) begin
                errors++;
                $display("FAIL rand_frame[%0d]: got ok=%b n=%0d word=%h want %h", i, ok, frm_q.size(), frm_q[0], exp_word);
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != t + LATENCY || vld_q[0] !== rd) begin
                errors++;
                $display("FAIL rand_done[%0d]: got n=%0d at %0d vld=%b want at %0d vld=%b",
                         i, done_q.size(), done_q[0], vld_q[0], t + LATENCY, rd);
            end
            checks++;
            if (rd_data !== last_rd) begin
                errors++;
                $display("FAIL rand_rd_data[%0d]: got %h want %h", i, rd_data, last_rd);
            end
        end
    endtask

`ifdef TI_ROIC_SPI_QUEUE_EN
    task automatic test_queue();
        int t; bit ok;
        logic [23:0] exp_w[6];
        pulse_reset();
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            exp_w[i] = {8'($urandom), 16'($urandom)};
            do_req(2'b01, exp_w[i][23:16], exp_w[i][15:0], t);
            if (i == 4) begin
                checks++;
                if (err_overrun !== 1'b0) begin errors++; $display("FAIL queue_no_err: got %b want 0", err_overrun); end
            end
        end
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL queue_overrun: got %b want 1", err_overrun); end
        wait_quiet(2000, ok);
        checks++;
        if (!ok || frm_q.size() != 5 || done_q.size() != 5) begin
            errors++;
            $display("FAIL queue_count: got ok=%b frames=%0d dones=%0d want 5 5", ok, frm_q.size(), done_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (frm_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL queue_frame[%0d]: got %h want %h", i, frm_q[i], exp_w[i]);
            end
        end
        checks++;
        if (m_min_gap < FRAME_GAP) begin
            errors++;
            $display("FAIL queue_gap: got %0d want >= %0d", m_min_gap, FRAME_GAP);
        end
    endtask
`else
    task automatic test_overrun();
        int t1, t2; bit ok;
        logic [7:0] a; logic [15:0] d;
        a = 8'($urandom); d = 16'($urandom);
        clear_mon();
        do_req(2'b01, a, d, t1);
        repeat (8) @(negedge clk);
        do_req(2'b01, 8'($urandom), 16'($urandom), t2);
        checks++;
        if (err_overrun !== 1'b1 || t2 - t1 != 10) begin
            errors++;
            $display("FAIL overrun_err: got err=%b offset=%0d want 1 10", err_overrun, t2 - t1);
        end
        wait_quiet(400, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || frm_q.size() != 1 || frm_q[0] !== {a, d} || done_q.size() != 1 || done_q[0] != t1 + LATENCY) begin
            errors++;
            $display("FAIL overrun_frames: got ok=%b n=%0d word=%h dones=%0d want 1 %h 1",
                     ok, frm_q.size(), frm_q[0], done_q.size(), {a, d});
        end
    endtask
`endif

    task automatic test_both();
        int t; bit ok;
        logic [7:0] a; logic [15:0] d;
        a = 8'($urandom); d = 16'($urandom);
        pulse_reset();
        clear_mon();
        do_req(2'b11, a, d, t);
        wait_quiet(400, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || frm_q.size() != 1 || frm_q[0] !== {a, d}) begin
            errors++;
            $display("FAIL both_frame: got ok=%b n=%0d word=%h want 1 %h", ok, frm_q.size(), frm_q[0], {a, d});
        end
        checks++;
        if (err_overrun !== 1'b1 || done_q.size() != 1 || vld_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL both_flags: got err=%b dones=%0d vld=%b want 1 1 0", err_overrun, done_q.size(), vld_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        int t; bit ok; bit hit;
        logic [7:0] a; logic [15:0] d;
        clear_mon();
        do_req(2'b01, 8'($urandom), 16'($urandom), t);
        hit = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (!roic_sen && m_nbits >= 11) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach: bit 10 never reached"); end
        reset = 1'b1;
        #1;
        checks++;
        if ({roic_sen, roic_sclk, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_outputs: got sen=%b sclk=%b busy=%b done=%b want 1 0 0 0",
                     roic_sen, roic_sclk, busy, done);
        end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_q.size() != 0) begin errors++; $display("FAIL midreset_done: got %0d dones want 0", done_q.size()); end
        clear_mon();
        a = 8'($urandom); d = 16'($urandom);
        do_req(2'b01, a, d, t);
        wait_quiet(400, ok);
        checks++;
        if (!ok || frm_q.size() != 1 || frm_q[0] !== {a, d} || bits_q[0] != 24) begin
            errors++;
            $display("FAIL midreset_refill: got ok=%b n=%0d word=%h bits=%0d want %h 24",
                     ok, frm_q.size(), frm_q[0], bits_q[0], {a, d});
        end
    endtask

    initial begin
        logic [15:0] last_rd;
        test_reset();
        test_write_basic();
        test_read_basic();
        last_rd = 16'hBEEF;
        test_random(last_rd);
`ifdef TI_ROIC_SPI_QUEUE_EN
        test_queue();
`else
        test_overrun();
`endif
        test_both();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
